// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide, one bit per cycle.
// Latency: start accepted at edge N -> done pulse after edge N+32 (special cases after N).
// Backpressure: start is taken only while busy=0 (IDLE or DONE); a start during CALC is dropped.
// Ports: clk, rst_n (sync, active-low), start/op/a/b request, busy, done pulse, result (held).
// Build option: define MD_DIV_EN to compile DIV/DIVU/REM/REMU; otherwise ops 1xx finish
// immediately with result 0.
module md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q;
  logic [2*XLEN-1:0] acc_q, acc_d;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q;         // multiplicand magnitude or divisor magnitude
  logic [1:0]        op_q;
  logic              neg_q;          // final negation of the selected result
  logic [4:0]        cnt_q;
`ifdef MD_DIV_EN
  logic              div_q;
`endif

  // Accept-time decode: signedness, magnitudes, special cases.
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            spec_d;
  logic [XLEN-1:0] spec_res_d;

  always_comb begin
    a_sgn = (op == 3'b001) || (op == 3'b010);
    b_sgn = (op == 3'b001);
    spec_d     = 1'b0;
    spec_res_d = '0;
`ifdef MD_DIV_EN
    if ((op == 3'b100) || (op == 3'b110)) begin
      a_sgn = 1'b1;
      b_sgn = 1'b1;
    end
    if (op[2] && (b == '0)) begin
      spec_d     = 1'b1;
      spec_res_d = op[1] ? a : '1;
    end else if (!op[0] && op[2] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
      // Signed overflow: quotient saturates to the dividend, remainder is zero.
      spec_d     = 1'b1;
      spec_res_d = op[1] ? '0 : a;
    end
`else
    if (op[2]) begin
      spec_d     = 1'b1;
      spec_res_d = '0;
    end
`endif
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration step plus the signed result it would produce if it is the last one.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_res;
`ifdef MD_DIV_EN
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   dsel;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_d   = {mul_sum, acc_q[XLEN-1:1]};
    prod    = neg_q ? -acc_d : acc_d;
    fin_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MD_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder, try to subtract.
    trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    dsel  = '0;
    if (div_q) begin
      if (!trial[XLEN]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else              acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      dsel    = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
      fin_res = neg_q ? -dsel : dsel;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MD_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            cnt_q <= '0;
            op_q  <= op[1:0];
            if (spec_d) begin
              state_q <= S_DONE;
              done    <= 1'b1;
              result  <= spec_res_d;
            end else begin
              state_q <= S_CALC;
              busy    <= 1'b1;
`ifdef MD_DIV_EN
              div_q   <= op[2];
              if (op[2]) begin
                opnd_q <= b_mag;
                acc_q  <= {{XLEN{1'b0}}, a_mag};
                // Remainder follows the dividend; quotient sign is the xor.
                neg_q  <= op[1] ? a_neg : (a_neg ^ b_neg);
              end else
`endif
              begin
                opnd_q <= a_mag;
                acc_q  <= {{XLEN{1'b0}}, b_mag};
                neg_q  <= a_neg ^ b_neg;
              end
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= fin_res;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative RV32M multiply/divide unit. It is the multi-cycle counterpart to the single-cycle `alu`: the execute stage routes M-extension instructions here instead of to the ALU. The unit accepts operands with a start pulse, holds `busy` while iterating one bit per cycle, and returns the 32-bit result with a one-cycle `done` pulse.

## Interface

Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 operand; sampled together with `start`.
- `b`  in  32  rs2 operand; sampled together with `start`.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  final value; held until the next accepted `start`.

## Operation

- States:
  - IDLE: waiting for a request.
  - CALC: iterating; `busy`=1.
  - DONE: `done`=1, lasts exactly one cycle, then returns to IDLE.
- Acceptance:
  - `start`=1 in IDLE or DONE latches `op`, `a` and `b` and moves to CALC, or straight to DONE for a special case.
  - `start` during CALC is ignored. The request is lost, and the caller must wait for `busy`=0.
- Sign handling:
  - Operands are converted to magnitudes at accept time.
  - Signedness per op: MULH treats both as signed. MULHSU treats `a` as signed and `b` as unsigned. DIV and REM are signed. The U variants and MUL are unsigned; MUL's low word is sign-independent.
  - The result sign is applied on the CALC→DONE transition.
- Multiply:
  - 32-iteration shift-add into a 64-bit accumulator.
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32] of the correctly signed 64-bit product.
- Divide:
  - 32-iteration restoring division on magnitudes.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Special cases skip CALC and go directly to DONE:
  - `b`=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Iteration counter: 5 bits. It is cleared on accept and CALC exits when it wraps from 31.
- Reset, whenever `rst_n`=0 at an edge, including mid-CALC:
  - state→IDLE, `busy`=0, `done`=0, `result`=0.
  - The accumulator and counter are cleared and any in-flight operation is abandoned without a `done` pulse.

## Timing

- Reset values: `busy`=0, `done`=0, `result`=0x00000000.
- Normal latency: `start` sampled at edge N → `busy`=1 after N → `done`=1 and `result` valid after edge N+32 (state DONE) → IDLE after N+33.
  - Issue interval: 33 cycles, since `start` is accepted while `done` is high.
- Special-case latency: `start` at edge N → `done`=1 after N, `busy` stays 0.
- `result` changes only on entry to DONE or on reset.
- `done` and `busy` are never high in the same cycle.
- `start` and `rst_n`=0 at the same edge: reset wins.

## Configuration

- `MD_DIV_EN`:
  - Defined: all eight ops are implemented as above.
  - Undefined: the divider datapath and the special-case logic are not compiled. Ops 100–111 take the special-case path (`done` one cycle after start, no `busy`) and return 0x00000000. Multiply behaviour and timing are unchanged.

## Test plan

- MUL and MULHU: `a`=0x00000007, `b`=0x00000006 → `result`=0x0000002A at `done`, 33 edges after start. Then `a`=`b`=0xFFFFFFFF with MULHU → 0xFFFFFFFE.
- Signed high multiply: MULH with `a`=0xFFFFFFFE (−2), `b`=0x00000003 → 0xFFFFFFFF. MULHSU with `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV with `a`=0xFFFFFFF9 (−7), `b`=2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). DIVU with `a`=100, `b`=7 → 14. REMU with the same operands → 2.
- Special cases, each with `done` one cycle after start and `busy` never asserted:
  - DIV with `b`=0, `a`=0x12345678 → 0xFFFFFFFF.
  - REM with `b`=0, `a`=0x12345678 → 0x12345678.
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Handshake:
  - A second `start` with different operands at edge N+10 is ignored; the first result is returned at N+32.
  - `start` issued while `done`=1 is accepted, giving back-to-back results 33 cycles apart.
- Reset mid-CALC: `rst_n`=0 at edge N+15 → `busy`=0, `result`=0, and no `done` pulse. A fresh MUL 3×5 after release returns 0x0000000F.
